// File: rtl/cmp_85_bus_pkg.sv
// Shared constants for the 74xx85-style magnitude comparator.
// Contents:
//   CMP_W  default operand width used by the comparator, its interface and its wrapper.
package cmp_85_bus_pkg;

  localparam int unsigned CMP_W = 4;

endpackage : cmp_85_bus_pkg

// File: rtl/cmp_85_bus_if.sv
// Bus interface for the magnitude comparator.
// Groups the operand inputs, the cascade inputs and the combinational and registered flag outputs.
// Modports:
//   master  drives a, b, ilt, igt, ieq and observes every flag output (ALU side / bench)
//   slave   the comparator side: consumes the operands and the cascade inputs, drives the flags
// Signals:
//   a, b           unsigned operands, WIDTH bits
//   ilt, igt, ieq  cascade inputs; only ieq has an effect (it qualifies qeq)
//   qlt, qgt, qeq  combinational compare result
//   qlt_r..qeq_r   the same three flags, registered
interface cmp_85_bus_if
  import cmp_85_bus_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ilt;
  logic             igt;
  logic             ieq;
  logic             qlt;
  logic             qgt;
  logic             qeq;
  logic             qlt_r;
  logic             qgt_r;
  logic             qeq_r;

  modport master (
    output a, b, ilt, igt, ieq,
    input  qlt, qgt, qeq, qlt_r, qgt_r, qeq_r
  );

  modport slave (
    input  a, b, ilt, igt, ieq,
    output qlt, qgt, qeq, qlt_r, qgt_r, qeq_r
  );

endinterface : cmp_85_bus_if

// File: rtl/cmp_85_core.sv
// Pure combinational unsigned magnitude compare.
// Ports:
//   a_i, b_i   operands, WIDTH bits, unsigned
//   ieq_i      cascade equal-in; gates the equal result
//   qlt_o      1 iff a_i < b_i
//   qgt_o      1 iff a_i > b_i
//   qeq_o      ieq_i when a_i == b_i, else 0
module cmp_85_core
  import cmp_85_bus_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ieq_i,
  output logic             qlt_o,
  output logic             qgt_o,
  output logic             qeq_o
);

  logic eq;

  always_comb begin
    qlt_o = 1'b0;
    qgt_o = 1'b0;
    eq    = 1'b0;
    if (a_i < b_i) begin
      qlt_o = 1'b1;
    end else if (a_i > b_i) begin
      qgt_o = 1'b1;
    end else begin
      eq = 1'b1;
    end
    // AND with a known 0 forces a clean 0 even when ieq_i is X/Z.
    qeq_o = eq & ieq_i;
  end

endmodule : cmp_85_core

// File: rtl/cmp_85_bus.sv
// 74xx85-style magnitude comparator, bus variant, for the ALU flag path.
// Combinational flags come straight from cmp_85_core; a 3-bit register keeps a one-cycle-delayed
// copy for the sequential flag logic, cleared asynchronously by rst_n.
// Ports:
//   clk    rising-edge clock, only used by the flag register
//   rst_n  asynchronous active-low reset of the flag register
//   bus    cmp_85_bus_if slave modport (operands, cascade inputs, flag outputs)
module cmp_85_bus
  import cmp_85_bus_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_85_bus_if.slave       bus
);

  logic       qlt;
  logic       qgt;
  logic       qeq;
  logic [2:0] flags_d;
  logic [2:0] flags_q;

  // ilt/igt exist for pin compatibility only; they never reach the compare.
  logic unused_cascade;
  assign unused_cascade = bus.ilt ^ bus.igt;

  cmp_85_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .ieq_i (bus.ieq),
    .qlt_o (qlt),
    .qgt_o (qgt),
    .qeq_o (qeq)
  );

  always_comb begin
    flags_d = {qlt, qgt, qeq};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.qlt   = qlt;
  assign bus.qgt   = qgt;
  assign bus.qeq   = qeq;
  assign bus.qlt_r = flags_q[2];
  assign bus.qgt_r = flags_q[1];
  assign bus.qeq_r = flags_q[0];

endmodule : cmp_85_bus

// File: tb/tb_cmp_85_bus.sv
// Directed bench for cmp_85_bus: exhaustive magnitude compare, equality passthrough,
// cascade-in independence and the registered flag path with its asynchronous clear.
module tb_cmp_85_bus;
  import cmp_85_bus_pkg::*;

  logic clk;
  logic clk_en;
  logic rst_n;
  int   total;
  int   bad;

  cmp_85_bus_if #(.WIDTH(CMP_W)) bus_if ();

  cmp_85_bus #(
    .WIDTH (CMP_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    bus_if.a   = 4'd0;
    bus_if.b   = 4'd0;
    bus_if.ilt = 1'b0;
    bus_if.igt = 1'b0;
    bus_if.ieq = 1'b0;
    #2;

    // Reset with the clock stopped: the flag register must clear on its own.
    rst_n = 1'b0;
    #1;
    check("rst_qlt_r", bus_if.qlt_r, 1'b0);
    check("rst_qgt_r", bus_if.qgt_r, 1'b0);
    check("rst_qeq_r", bus_if.qeq_r, 1'b0);

    // Exhaustive compare with every cascade input unknown.
    bus_if.ilt = 1'bx;
    bus_if.igt = 1'bx;
    bus_if.ieq = 1'bx;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        bus_if.a = 4'(i);
        bus_if.b = 4'(j);
        #1;
        check($sformatf("exh_qlt_%0d_%0d", i, j), bus_if.qlt, (i < j) ? 1'b1 : 1'b0);
        check($sformatf("exh_qgt_%0d_%0d", i, j), bus_if.qgt, (i > j) ? 1'b1 : 1'b0);
        if (i != j) begin
          check($sformatf("exh_qeq_%0d_%0d", i, j), bus_if.qeq, 1'b0);
        end
      end
    end

    // Equality passthrough, including the 0/0 and 15/15 boundaries.
    bus_if.ilt = 1'b0;
    bus_if.igt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_if.a   = 4'(i);
      bus_if.b   = 4'(i);
      bus_if.ieq = 1'b0;
      #1;
      check($sformatf("eq_ieq0_qeq_%0d", i), bus_if.qeq, 1'b0);
      check($sformatf("eq_ieq0_qlt_%0d", i), bus_if.qlt, 1'b0);
      check($sformatf("eq_ieq0_qgt_%0d", i), bus_if.qgt, 1'b0);
      bus_if.ieq = 1'b1;
      #1;
      check($sformatf("eq_ieq1_qeq_%0d", i), bus_if.qeq, 1'b1);
    end

    // Unequal operands with ieq high.
    bus_if.a = 4'd3; bus_if.b = 4'd9; bus_if.ieq = 1'b1;
    #1;
    check("neq_3_9_qlt", bus_if.qlt, 1'b1);
    check("neq_3_9_qgt", bus_if.qgt, 1'b0);
    check("neq_3_9_qeq", bus_if.qeq, 1'b0);

    // Cascade lt/gt inputs must not leak into the result.
    bus_if.a = 4'd7; bus_if.b = 4'd7; bus_if.ilt = 1'b1; bus_if.igt = 1'b1;
    #1;
    check("casc_qlt", bus_if.qlt, 1'b0);
    check("casc_qgt", bus_if.qgt, 1'b0);
    check("casc_qeq", bus_if.qeq, 1'b1);

    // Boundaries.
    bus_if.ilt = 1'b0; bus_if.igt = 1'b0;
    bus_if.a = 4'd0; bus_if.b = 4'd15;
    #1;
    check("bnd_0_15_qlt", bus_if.qlt, 1'b1);
    check("bnd_0_15_qgt", bus_if.qgt, 1'b0);
    bus_if.a = 4'd15; bus_if.b = 4'd0;
    #1;
    check("bnd_15_0_qgt", bus_if.qgt, 1'b1);
    check("bnd_15_0_qlt", bus_if.qlt, 1'b0);

    // Registered path: still in reset, nothing captured yet.
    bus_if.a = 4'd12; bus_if.b = 4'd5;
    #1;
    check("hold_qgt_r", bus_if.qgt_r, 1'b0);
    rst_n  = 1'b1;
    #1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    check("reg_12_5_qgt_r", bus_if.qgt_r, 1'b1);
    check("reg_12_5_qlt_r", bus_if.qlt_r, 1'b0);
    check("reg_12_5_qeq_r", bus_if.qeq_r, 1'b0);

    // One-cycle latency: a new compare is not visible until the next edge.
    bus_if.a = 4'd2; bus_if.b = 4'd9;
    #1;
    check("lat_before_qlt_r", bus_if.qlt_r, 1'b0);
    check("lat_before_qgt_r", bus_if.qgt_r, 1'b1);
    @(posedge clk);
    #1;
    check("lat_after_qlt_r", bus_if.qlt_r, 1'b1);
    check("lat_after_qgt_r", bus_if.qgt_r, 1'b0);

    // Equal result with ieq high is captured as qeq_r.
    bus_if.a = 4'd4; bus_if.b = 4'd4; bus_if.ieq = 1'b1;
    @(posedge clk);
    #1;
    check("reg_eq_qeq_r", bus_if.qeq_r, 1'b1);
    check("reg_eq_qlt_r", bus_if.qlt_r, 1'b0);

    // Mid-run async reset between edges.
    bus_if.a = 4'd12; bus_if.b = 4'd5;
    @(posedge clk);
    #1;
    check("pre_rst_qgt_r", bus_if.qgt_r, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_qgt_r", bus_if.qgt_r, 1'b0);
    check("mid_rst_qlt_r", bus_if.qlt_r, 1'b0);
    check("mid_rst_qeq_r", bus_if.qeq_r, 1'b0);
    check("mid_rst_qgt",   bus_if.qgt,   1'b1);
    check("mid_rst_qlt",   bus_if.qlt,   1'b0);
    check("mid_rst_qeq",   bus_if.qeq,   1'b0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_qgt_r", bus_if.qgt_r, 1'b1);

    clk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cmp_85_bus
